// File: rtl/booth_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_arith_pkg
// Description : Shared types and constants for the Booth arithmetic datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_W_DEFAULT = 4;

    // Counter must hold 0 .. w-1.
    function automatic int div_cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_addsub_stage.sv
`default_nettype none
// ============================================================================
// Module      : div_addsub_stage
// Description : One non-restoring step: add or subtract D from the shifted
//               partial remainder, chosen by the pre-shift sign of P.
// Revision    : 1.0 - initial release
// ============================================================================
module div_addsub_stage
    import booth_arith_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
)
(
    input  logic [W:0] p_shift,
    input  logic [W:0] d,
    input  logic       p_neg,
    output logic [W:0] p_next,
    output logic       q_bit
);

    always_comb begin
        p_next = p_neg ? (p_shift + d) : (p_shift - d);
        q_bit  = ~p_next[W];
    end

endmodule
`default_nettype wire

// File: rtl/booth_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_divider
// Description : Sequential radix-2 non-restoring divider, one quotient bit per
//               clock, start/done handshake, fixed W+2 cycle latency.
//               Define BOOTH_DIV_SIGNED_EN for two's-complement operands.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_divider
    import booth_arith_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int             CNT_W = div_cnt_w(W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    div_state_t       state_q, state_d;
    logic [W:0]       p_q, p_d;
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     d_q, d_d;
    logic [W-1:0]     dvd_q, dvd_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [W-1:0]     quot_q, quot_d;
    logic [W-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     dvd_mag;
    logic [W-1:0]     dvs_mag;
    logic [W:0]       p_shift;
    logic [W:0]       p_next;
    logic             q_bit;
    logic [W-1:0]     p_fix;
    logic [W-1:0]     quo_res;
    logic [W-1:0]     rem_res;
    logic             dbz_res;
    logic             ovf_res;

`ifdef BOOTH_DIV_SIGNED_EN
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic sgn_quo_q, sgn_quo_d;
    logic sgn_rem_q, sgn_rem_d;

    always_comb begin
        dvd_mag = dividend[W-1] ? (-dividend) : dividend;
        dvs_mag = divisor[W-1]  ? (-divisor)  : divisor;
    end
`else
    always_comb begin
        dvd_mag = dividend;
        dvs_mag = divisor;
    end
`endif

    always_comb begin
        p_shift = {p_q[W-1:0], q_q[W-1]};
    end

    div_addsub_stage #(
        .W (W)
    ) u_addsub (
        .p_shift (p_shift),
        .d       ({1'b0, d_q}),
        .p_neg   (p_q[W]),
        .p_next  (p_next),
        .q_bit   (q_bit)
    );

    // Final remainder is non-negative and below 2^W, so W bits suffice.
    always_comb begin
        p_fix   = p_q[W] ? (p_q[W-1:0] + d_q) : p_q[W-1:0];
`ifdef BOOTH_DIV_SIGNED_EN
        quo_res = sgn_quo_q ? (-q_q)   : q_q;
        rem_res = sgn_rem_q ? (-p_fix) : p_fix;
`else
        quo_res = q_q;
        rem_res = p_fix;
`endif
        dbz_res = 1'b0;
        ovf_res = 1'b0;
        if (dvs_q == '0) begin
            quo_res = '1;
            rem_res = dvd_q;
            dbz_res = 1'b1;
        end
`ifdef BOOTH_DIV_SIGNED_EN
        else if ((dvd_q == MOST_NEG) && (dvs_q == '1)) begin
            quo_res = dvd_q;
            rem_res = '0;
            ovf_res = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        iter_d  = iter_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
`ifdef BOOTH_DIV_SIGNED_EN
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    q_d     = dvd_mag;
                    d_d     = dvs_mag;
                    p_d     = '0;
                    iter_d  = '0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
`ifdef BOOTH_DIV_SIGNED_EN
                    sgn_quo_d = dividend[W-1] ^ divisor[W-1];
                    sgn_rem_d = dividend[W-1];
`endif
                end
            end
            CALC: begin
                p_d    = p_next;
                q_d    = {q_q[W-2:0], q_bit};
                iter_d = iter_q + CNT_W'(1);
                if (iter_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = quo_res;
                rem_d   = rem_res;
                dbz_d   = dbz_res;
                ovf_d   = ovf_res;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            iter_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef BOOTH_DIV_SIGNED_EN
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            iter_q  <= iter_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
`ifdef BOOTH_DIV_SIGNED_EN
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
`endif
        end
    end

    always_comb begin
        busy        = (state_q == CALC) || (state_q == FIX);
        done        = (state_q == DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_divider
// Description : Scoreboard bench for booth_seq_divider with W=4 directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_divider;

    localparam int W = 4;
`ifdef BOOTH_DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    booth_seq_divider #(
        .W (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ov;
        int           at;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // Monitor: pop the oldest expectation on every done pulse, then confirm
    // the results are still held on the following cycle.
    exp_t last;
    bit   hold_pending = 1'b0;
    always @(negedge clk) begin
        if (hold_pending) begin
            hold_pending = 1'b0;
            check({last.name, "_hold"}, {quotient, remainder}, {last.q, last.r});
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                last = sb.pop_front();
                check({last.name, "_latency"}, cyc, last.at);
                check({last.name, "_result"},
                      {quotient, remainder, div_by_zero, overflow, busy},
                      {last.q, last.r, last.dbz, last.ov, 1'b0});
                hold_pending = 1'b1;
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] qe, input logic [W-1:0] re,
                            input logic dbz, input logic ov, input int acc, input string nm);
        exp_t e;
        e.q = qe; e.r = re; e.dbz = dbz; e.ov = ov; e.at = acc + W + 1; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] qe, input logic [W-1:0] re,
                         input logic dbz, input logic ov, input string nm,
                         input bit push, output int acc);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
        check({nm, "_accept"}, {busy, div_by_zero, overflow}, 3'b100);
        if (push) push_exp(qe, re, dbz, ov, acc, nm);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({nm, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] qe, input logic [W-1:0] re,
                       input logic dbz, input logic ov, input string nm);
        int acc;
        issue(a, b, qe, re, dbz, ov, nm, 1'b1, acc);
        wait_done(nm);
    endtask

    initial begin
        int acc;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, '0);
        rst_n = 1'b1;

        run(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0, "div_7_2");
        run(4'h9, 4'd2, SGN ? 4'hD : 4'd4, SGN ? 4'hF : 4'd1, 1'b0, 1'b0, "div_m7_2");
        run(4'd7, 4'hE, SGN ? 4'hD : 4'd0, SGN ? 4'd1 : 4'd7, 1'b0, 1'b0, "div_7_m2");
        run(4'hA, 4'hD, SGN ? 4'd2 : 4'd0, SGN ? 4'd0 : 4'hA, 1'b0, 1'b0, "div_m6_m3");
        run(4'd5, 4'd0, 4'hF, 4'd5, 1'b1, 1'b0, "div_by_zero");
        run(4'd3, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0, "div_3_1");
        run(4'h8, 4'hF, SGN ? 4'h8 : 4'd0, SGN ? 4'd0 : 4'd8, 1'b0, SGN, "div_ovf");
        run(4'd15, 4'd4, SGN ? 4'd0 : 4'd3, SGN ? 4'hF : 4'd3, 1'b0, 1'b0, "div_15_4");

        // A start held high while busy must be ignored; being still high in
        // IDLE it is then accepted exactly once, W+3 edges after the first.
        issue(4'd7, 4'd3, 4'd2, 4'd1, 1'b0, 1'b0, "busy_first", 1'b1, acc);
        @(negedge clk);
        dividend = 4'd6;
        divisor  = 4'd3;
        start    = 1'b1;
        wait_done("busy_first");
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept", {busy, div_by_zero, overflow}, 3'b100);
        push_exp(4'd2, 4'd0, 1'b0, 1'b0, acc + W + 3, "busy_second");
        wait_done("busy_second");

        issue(4'd7, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, "abort", 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {busy, done, quotient, remainder, div_by_zero, overflow}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_idle", {busy, done}, 2'b00);

        run(4'd9, 4'd4, SGN ? 4'hF : 4'd2, SGN ? 4'hD : 4'd1, 1'b0, 1'b0, "post_reset_9_4");

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
